// File: rtl/rx2_buffer_if.sv
// rx2_buffer_if: two-phase flit input, valid/ready flit output and accepted-flit count.
interface rx2_buffer_if #(parameter int SIZE = 8);
   logic            req;
   logic [SIZE-1:0] data;
   logic            ack;
   logic            out_valid;
   logic [SIZE-1:0] out_data;
   logic            out_ready;
   logic [7:0]      count;
   modport master (output req, data, out_ready, input ack, out_valid, out_data, count);
   modport slave  (input req, data, out_ready, output ack, out_valid, out_data, count);
endinterface

// File: rtl/rx2_buffer.sv
// rx2_buffer: two-phase req/ack receive endpoint feeding a FIFO with valid/ready output.
module rx2_buffer #(
   parameter int SIZE  = 8,
   parameter int DEPTH = 4
) (
   input logic         clk,
   input logic         reset,
   rx2_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   logic [SIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     occ_q, occ_d;
   logic            ack_q;
   logic [7:0]      count_q;
   logic            accept, pop;
   // Full test uses registered occupancy, so a same-cycle pop never frees a slot early.
   assign accept = (bus.req ^ ack_q) && (occ_q != FULL);
   assign pop    = (occ_q != '0) && bus.out_ready;
   always_comb begin
      occ_d = (accept && !pop) ? occ_q + 1'b1 : (!accept && pop) ? occ_q - 1'b1 : occ_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         ack_q    <= 1'b0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            mem_q[wr_ptr_q] <= bus.data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            ack_q           <= ~ack_q;
            count_q         <= (count_q == 8'hFF) ? count_q : count_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         occ_q <= occ_d;
      end
   end
   assign bus.ack       = ack_q;
   assign bus.out_valid = (occ_q != '0);
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.count     = count_q;
endmodule

// File: tb/tb_rx2_buffer.sv
// tb_rx2_buffer: directed and random stimulus checked against a queue-based model.
module tb_rx2_buffer;
   localparam int SIZE = 8;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   logic [SIZE-1:0] q [$];
   logic [SIZE-1:0] got [$];
   logic m_ack;
   int cnt;
   rx2_buffer_if #(.SIZE(SIZE)) bus ();
   rx2_buffer #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict from the flit-level rules, advance, then compare outputs.
   task automatic cyc();
      bit acc, pp;
      logic [SIZE-1:0] d;
      pp  = (q.size() > 0) && bus.out_ready;
      acc = (bus.req ^ m_ack) && (q.size() < DEPTH);
      d   = bus.data;
      if (!reset && pp) begin
         chk("pop_data", 32'(bus.out_data), 32'(q[0]));
         got.push_back(q[0]);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         m_ack = 1'b0;
         cnt = 0;
      end else begin
         if (pp) void'(q.pop_front());
         if (acc) begin
            q.push_back(d);
            m_ack = ~m_ack;
            cnt = (cnt == 255) ? 255 : cnt + 1;
         end
      end
      chk("ack", 32'(bus.ack), 32'(m_ack));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("count", 32'(bus.count), 32'(cnt));
      if (q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = 1'b0;
      bus.out_ready = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_data", 32'(bus.out_data), 0);
      chk("rst_count", 32'(bus.count), 0);
      got.delete();
   endtask

   task automatic send(input logic [SIZE-1:0] v);
      int k;
      bus.data = v;
      bus.req = ~bus.req;
      for (k = 0; k < 50 && bus.ack !== bus.req; k++) cyc();
      if (k == 50) chk("send_timeout", 32'(bus.ack), 32'(bus.req));
   endtask

   task automatic drain();
      int k;
      bus.out_ready = 1'b1;
      for (k = 0; k < 50 && bus.out_valid; k++) cyc();
      bus.out_ready = 1'b0;
      chk("drain_empty", 32'(bus.out_valid), 0);
   endtask

   initial begin
      int n, k;
      m_ack = 1'b0;
      cnt = 0;
      bus.data = '0;
      do_reset();
      repeat (3) cyc();
      chk("idle_ack", 32'(bus.ack), 0);
      chk("idle_valid", 32'(bus.out_valid), 0);

      // single flit
      bus.data = 8'd4;
      bus.req = 1'b1;
      cyc();
      chk("single_ack", 32'(bus.ack), 1);
      chk("single_valid", 32'(bus.out_valid), 1);
      chk("single_data", 32'(bus.out_data), 4);
      chk("single_count", 32'(bus.count), 1);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("single_popped", 32'(bus.out_valid), 0);

      // backpressure with DEPTH flits held
      do_reset();
      for (int i = 1; i <= 4; i++) send(SIZE'(i));
      chk("bp_count4", 32'(bus.count), 4);
      bus.data = 8'd5;
      bus.req = ~bus.req;
      repeat (4) cyc();
      chk("bp_frozen", 32'(bus.ack != bus.req), 1);
      chk("bp_count_hold", 32'(bus.count), 4);
      chk("bp_head", 32'(bus.out_data), 1);
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      chk("bp_no_early_accept", 32'(bus.ack != bus.req), 1);
      cyc();
      chk("bp_accept5", 32'(bus.ack == bus.req), 1);
      chk("bp_count5", 32'(bus.count), 5);
      got.delete();
      drain();
      chk("bp_order_n", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk("bp_order", 32'(got[i]), 32'(i + 2));

      // simultaneous push and pop at occupancy 2
      do_reset();
      send(8'hA1);
      send(8'hB2);
      bus.out_ready = 1'b1;
      bus.data = 8'hC3;
      bus.req = ~bus.req;
      cyc();
      bus.out_ready = 1'b0;
      chk("sim_ack", 32'(bus.ack == bus.req), 1);
      chk("sim_occ", q.size(), 2);
      chk("sim_head", 32'(bus.out_data), 32'hB2);
      drain();
      chk("sim_order_n", got.size(), 3);
      if (got.size() == 3) begin
         chk("sim_o0", 32'(got[0]), 32'hA1);
         chk("sim_o1", 32'(got[1]), 32'hB2);
         chk("sim_o2", 32'(got[2]), 32'hC3);
      end

      // wrap and ordering with out_ready toggling
      do_reset();
      n = 0;
      for (k = 0; k < 400 && got.size() < 10; k++) begin
         bus.out_ready = ~bus.out_ready;
         if (bus.req == bus.ack && n < 10) begin
            n++;
            bus.data = SIZE'(n);
            bus.req = ~bus.req;
         end
         cyc();
      end
      bus.out_ready = 1'b0;
      chk("wrap_n", got.size(), 10);
      for (int i = 0; i < 10 && i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i + 1));
      chk("wrap_count", 32'(bus.count), 10);

      // random traffic to saturation
      do_reset();
      n = 0;
      for (k = 0; k < 20000 && (n < 300 || bus.req != bus.ack); k++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (bus.req == bus.ack && n < 300 && $urandom_range(0, 3) != 0) begin
            n++;
            bus.data = SIZE'($urandom);
            bus.req = ~bus.req;
         end
         cyc();
      end
      chk("sat_done", 32'(bus.req == bus.ack), 1);
      chk("sat_count", 32'(bus.count), 255);

      // reset while holding three flits with a request pending
      drain();
      for (int i = 0; i < 3; i++) send(SIZE'($urandom));
      chk("mid_occ3", q.size(), 3);
      bus.data = 8'h77;
      bus.req = ~bus.req;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("mid_ack", 32'(bus.ack), 0);
      chk("mid_count", 32'(bus.count), 0);
      chk("mid_valid", 32'(bus.out_valid), 0);
      chk("mid_data", 32'(bus.out_data), 0);
      cyc();
      chk("post_rst_req", 32'(bus.ack), 32'(bus.req));
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
